// File: rtl/dwisehart_ring_pkg.sv
// Shared definitions for the ring-oscillator scan chain reader.
//   state_t    : reader FSM states
//   DIG_*      : digit index carried in the low two bits of the select
//   ERR_COUNT  : count reported when any digit decodes above 9
//   SEL_W      : width of the scan mux select
package dwisehart_ring_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [1:0] DIG_100 = 2'd0;
    localparam logic [1:0] DIG_010 = 2'd1;
    localparam logic [1:0] DIG_001 = 2'd2;

    localparam logic [9:0] ERR_COUNT = 10'h3FF;

    localparam int SEL_W = 6;

endpackage

// File: rtl/grey_digit_decode.sv
// Combinational grey-code digit decoder.
//   grey : 5-bit grey-coded digit
//   bin  : low four bits of the binary value (meaningful only when over=0)
//   over : binary value is above 9
module grey_digit_decode (
    input  logic [4:0] grey,
    output logic [3:0] bin,
    output logic       over
);

    logic [4:0] b;

    // Each binary bit is the parity of the grey bits at and above it.
    always_comb begin
        b[4] = grey[4];
        b[3] = ^grey[4:3];
        b[2] = ^grey[4:2];
        b[1] = ^grey[4:1];
        b[0] = ^grey[4:0];
    end

    assign bin  = b[3:0];
    assign over = (b > 5'd9);

endmodule

// File: rtl/scan_reader.sv
// Host-side reader for the ring-oscillator measurement scan chain.
// Sweeps pCHANNELS channels; for each one it selects the hundreds, tens and
// ones digit in turn, waits pSETTLE cycles, samples the grey digit on the LED
// bus, and finally offers a decoded 0..999 count on a valid/ready handshake.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin a sweep (only looked at in IDLE)
//   o_sel          : scan mux select {chan, digit}
//   i_led          : LED bus; [4:0] grey digit, [7:5] ignored
//   o_busy         : reader is not idle
//   o_valid/i_ready: record handshake carrying o_chan, o_count, o_err
//   o_done         : one-cycle pulse after the last record is taken
module scan_reader
    import dwisehart_ring_pkg::*;
#(
    parameter int pSETTLE   = 4,
    parameter int pCHANNELS = 14
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic [SEL_W-1:0] o_sel,
    input  logic [7:0]       i_led,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [3:0]       o_chan,
    output logic [9:0]       o_count,
    output logic             o_err,
    output logic             o_done
);

    localparam logic [3:0] SETTLE_LAST = 4'(pSETTLE - 1);
    localparam logic [3:0] CHAN_LAST   = 4'(pCHANNELS - 1);

    state_t     state, state_nxt;
    logic [3:0] chan, chan_nxt;
    logic [1:0] digit, digit_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [9:0] acc, acc_nxt;
    logic       err, err_nxt;

    logic [SEL_W-1:0] sel_nxt;
    logic             valid_nxt;
    logic [3:0]       ochan_nxt;
    logic [9:0]       count_nxt;
    logic             oerr_nxt;
    logic             done_nxt;

    logic [3:0] dig_bin;
    logic       dig_over;
    logic [9:0] acc_mac;
    logic       err_acc;
    logic       led_unused;

    assign led_unused = ^i_led[7:5];

    grey_digit_decode u_decode (
        .grey (i_led[4:0]),
        .bin  (dig_bin),
        .over (dig_over)
    );

    // Accumulate in 10 bits; only trusted while no digit has overflowed.
    assign acc_mac = 10'(acc * 10'd10) + 10'(dig_bin);
    assign err_acc = err | dig_over;

    assign o_busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        chan_nxt  = chan;
        digit_nxt = digit;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        err_nxt   = err;
        sel_nxt   = o_sel;
        valid_nxt = o_valid;
        ochan_nxt = o_chan;
        count_nxt = o_count;
        oerr_nxt  = o_err;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = SETTLE;
                    chan_nxt  = 4'd0;
                    digit_nxt = DIG_100;
                    cnt_nxt   = 4'd0;
                    acc_nxt   = 10'd0;
                    err_nxt   = 1'b0;
                    sel_nxt   = {4'd0, DIG_100};
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                acc_nxt = acc_mac;
                err_nxt = err_acc;
                if (digit == DIG_001) begin
                    state_nxt = OUT;
                    valid_nxt = 1'b1;
                    ochan_nxt = chan;
                    oerr_nxt  = err_acc;
                    count_nxt = err_acc ? ERR_COUNT : acc_mac;
                end else begin
                    state_nxt = SETTLE;
                    digit_nxt = digit + 2'd1;
                    cnt_nxt   = 4'd0;
                    sel_nxt   = {chan, digit + 2'd1};
                end
            end
            OUT: begin
                if (o_valid && i_ready) begin
                    valid_nxt = 1'b0;
                    if (chan == CHAN_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        sel_nxt   = '0;
                    end else begin
                        state_nxt = SETTLE;
                        chan_nxt  = chan + 4'd1;
                        digit_nxt = DIG_100;
                        cnt_nxt   = 4'd0;
                        acc_nxt   = 10'd0;
                        err_nxt   = 1'b0;
                        sel_nxt   = {chan + 4'd1, DIG_100};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            chan    <= 4'd0;
            digit   <= 2'd0;
            cnt     <= 4'd0;
            acc     <= 10'd0;
            err     <= 1'b0;
            o_sel   <= '0;
            o_valid <= 1'b0;
            o_chan  <= 4'd0;
            o_count <= 10'd0;
            o_err   <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            chan    <= chan_nxt;
            digit   <= digit_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            err     <= err_nxt;
            o_sel   <= sel_nxt;
            o_valid <= valid_nxt;
            o_chan  <= ochan_nxt;
            o_count <= count_nxt;
            o_err   <= oerr_nxt;
            o_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_scan_reader.sv
module tb_scan_reader;

    localparam int SETTLE = 4;
    localparam int CHANS  = 14;
    localparam int LAT    = 3 * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic [5:0] sel;
    logic [7:0] led;
    logic       busy, valid, err, done;
    logic [3:0] ochan;
    logic [9:0] count;

    logic [4:0] tab [0:15][0:3];

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int done_pulses = 0;
    bit dig3_seen = 1'b0;

    always #5 clk = ~clk;

    // Scan mux model: the addressed grey digit with junk in the ignored bits.
    assign led = {3'b101, tab[sel[5:2]][sel[1:0]]};

    scan_reader #(.pSETTLE(SETTLE), .pCHANNELS(CHANS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .o_sel   (sel),
        .i_led   (led),
        .o_busy  (busy),
        .o_valid (valid),
        .i_ready (ready),
        .o_chan  (ochan),
        .o_count (count),
        .o_err   (err),
        .o_done  (done)
    );

    always @(posedge clk) begin
        if (done) done_pulses <= done_pulses + 1;
        if (sel[1:0] == 2'd3) dig3_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int enc(input int d);
        return d ^ (d >> 1);
    endfunction

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < 5; s++) b = b ^ (g >> s);
        return b & 31;
    endfunction

    function automatic int exp_count(input int c);
        int h, t, o;
        h = g2b(int'(tab[c][0]));
        t = g2b(int'(tab[c][1]));
        o = g2b(int'(tab[c][2]));
        if (h > 9 || t > 9 || o > 9) return 'h3FF;
        return h * 100 + t * 10 + o;
    endfunction

    task automatic set_value(input int c, input int v);
        tab[c][0] = 5'(enc(v / 100));
        tab[c][1] = 5'(enc((v / 10) % 10));
        tab[c][2] = 5'(enc(v % 10));
        tab[c][3] = 5'd0;
    endtask

    task automatic set_random(input int c);
        for (int d = 0; d < 4; d++) begin
            if ($urandom_range(9) == 0) tab[c][d] = 5'($urandom_range(31));
            else                        tab[c][d] = 5'(enc($urandom_range(9)));
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for one record, check it, apply bp cycles of backpressure (or have
    // ready already high when pre=1), accept it, and check what follows.
    task automatic check_record(input int c, input int bp, input bit pre, input bit stray);
        int n = 0;
        int e;
        logic [20:0] snap;
        ready = pre;
        while (!valid && n < 200) begin
            if (stray && n == 3) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        e = exp_count(c);
        chk($sformatf("latency c%0d", c), 32'(n), 32'(LAT));
        chk($sformatf("chan c%0d", c), 32'(ochan), 32'(c));
        chk($sformatf("count c%0d", c), 32'(count), 32'(e));
        chk($sformatf("err c%0d", c), 32'(err), (e == 'h3FF) ? 32'd1 : 32'd0);
        chk($sformatf("sel_out c%0d", c), 32'(sel), 32'((c << 2) | 2));
        snap = {sel, ochan, count, err};
        if (!pre) begin
            for (int k = 0; k < bp; k++) begin
                tick();
                chk($sformatf("hold_valid c%0d", c), 32'(valid), 32'd1);
                chk($sformatf("hold_fields c%0d", c), 32'({sel, ochan, count, err}), 32'(snap));
            end
            ready = 1'b1;
        end
        tick();
        ready = 1'b0;
        chk($sformatf("valid_drop c%0d", c), 32'(valid), 32'd0);
        if (c == CHANS - 1) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sel", 32'(sel), 32'd0);
        end else begin
            chk($sformatf("next_busy c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("next_sel c%0d", c), 32'(sel), 32'((c + 1) << 2));
            chk($sformatf("no_done c%0d", c), 32'(done), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_chan"}, 32'(ochan), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        for (int c = 0; c < 16; c++) for (int d = 0; d < 4; d++) tab[c][d] = 5'd0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_start", 32'(busy), 32'd0);

        // Sweep 1: channel c reports c*7; a stray start mid-sweep is ignored.
        for (int c = 0; c < 16; c++) set_value(c, c * 7);
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_sel", 32'(sel), 32'd0);
        for (int c = 0; c < CHANS; c++) check_record(c, c % 3, c == 4, c == 2);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("done_count1", 32'(done_pulses), 32'd1);

        // Sweep 2: directed digit values, then reset while channel 5 settles.
        for (int c = 0; c < 16; c++) set_random(c);
        tab[0][0] = 5'd2;  tab[0][1] = 5'd6;  tab[0][2] = 5'd7;
        tab[1][0] = 5'd13; tab[1][1] = 5'd13; tab[1][2] = 5'd13;
        tab[2][0] = 5'd2;  tab[2][1] = 5'd15; tab[2][2] = 5'd7;
        tab[3][0] = 5'd0;  tab[3][1] = 5'd0;  tab[3][2] = 5'd0;
        chk("model_345", 32'(exp_count(0)), 32'd345);
        chk("model_999", 32'(exp_count(1)), 32'd999);
        chk("model_err", 32'(exp_count(2)), 32'h3FF);
        do_start();
        check_record(0, 5, 1'b0, 1'b0);
        check_record(1, 0, 1'b1, 1'b0);
        check_record(2, 1, 1'b0, 1'b0);
        check_record(3, 0, 1'b0, 1'b0);
        check_record(4, 2, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        chk("pre_reset_sel", 32'(sel), 32'(5 << 2));
        rst_n = 1'b0;
        #2;
        check_all_zero("async_reset");
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_valid", 32'(valid), 32'd0);
        chk("post_reset_sel", 32'(sel), 32'd0);
        chk("done_count_reset", 32'(done_pulses), 32'd1);

        // Sweep 3: fully random digits and handshake timing.
        for (int c = 0; c < 16; c++) set_random(c);
        do_start();
        for (int c = 0; c < CHANS; c++)
            check_record(c, $urandom_range(3), ($urandom_range(3) == 0), 1'b0);
        tick();
        chk("done_count2", 32'(done_pulses), 32'd2);
        chk("no_digit3", 32'(dig3_seen), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
